jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_pkg.sv | 26 ++
 rtl/jtag_ir.sv | 55 +++++
 rtl/jtag_tap_ctrl.sv | 94 +++++++++
 tb/tb_jtag_tap_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types and opcode constants for the JTAG TAP controller slice.
package jtag_pkg;

  localparam int IR_WIDTH_DEFAULT = 4;

  localparam logic [3:0] OP_IDCODE           = 4'h1;
  localparam logic [3:0] OP_ADDR_REGISTER    = 4'h2;
  localparam logic [3:0] OP_DATA_WR_REGISTER = 4'h3;
  localparam logic [3:0] OP_DATA_RD_REGISTER = 4'h4;
  localparam logic [3:0] OP_BYPASS           = 4'hF;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [2:0] {
    DEC_IDCODE,
    DEC_ADDR_REGISTER,
    DEC_DATA_WR_REGISTER,
    DEC_DATA_RD_REGISTER,
    DEC_BYPASS
  } ir_decoding_t;

endpackage

// File: rtl/jtag_ir.sv
// Instruction register: capture/shift on rising tck, latch on falling tck, decode of the latch.
import jtag_pkg::*;

module jtag_ir #(
  parameter int                  IR_WIDTH       = IR_WIDTH_DEFAULT,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(4'b0101)
) (
  input  logic         tck,
  input  logic         trstn,
  input  logic         tdi,
  input  logic         capture_ir,
  input  logic         shift_ir,
  input  logic         update_ir,
  input  logic         tlr,
  output logic         ir_sr_lsb,
  output ir_decoding_t ir_dec
);

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  always_comb begin
    ir_sr_d = ir_sr_q;
    if (capture_ir)    ir_sr_d = IR_CAPTURE_VAL;
    else if (shift_ir) ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) ir_sr_q <= '0;
    else        ir_sr_q <= ir_sr_d;
  end

  // Strobes come from the registered state, so they are stable across the falling edge.
  always_comb begin
    ir_d = ir_q;
    if (tlr)            ir_d = IR_WIDTH'(OP_IDCODE);
    else if (update_ir) ir_d = ir_sr_q;
  end

  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) ir_q <= IR_WIDTH'(OP_IDCODE);
    else        ir_q <= ir_d;
  end

  always_comb begin
    ir_dec = DEC_BYPASS;
    if      (ir_q == IR_WIDTH'(OP_IDCODE))           ir_dec = DEC_IDCODE;
    else if (ir_q == IR_WIDTH'(OP_ADDR_REGISTER))    ir_dec = DEC_ADDR_REGISTER;
    else if (ir_q == IR_WIDTH'(OP_DATA_WR_REGISTER)) ir_dec = DEC_DATA_WR_REGISTER;
    else if (ir_q == IR_WIDTH'(OP_DATA_RD_REGISTER)) ir_dec = DEC_DATA_RD_REGISTER;
  end

  assign ir_sr_lsb = ir_sr_q[0];

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, falling-edge tdo mux, IR sub-block.
import jtag_pkg::*;

module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH       = IR_WIDTH_DEFAULT,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(4'b0101)
) (
  input  logic          trstn,
  input  logic          tck,
  input  logic          tms,
  input  logic          tdi,
  input  logic          tdo_dr,
  output logic          tdo,
  output logic          tdo_en,
  output tap_ctrl_fsm_t tap_state,
  output ir_decoding_t  ir_dec
);

  tap_ctrl_fsm_t state_q, state_d;
  logic          tdo_q, tdo_d;
  logic          tdo_en_q, tdo_en_d;
  logic          ir_sr_lsb;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:       state_d = tms ? TLR       : RTI;
      RTI:       state_d = tms ? SEL_DR    : RTI;
      SEL_DR:    state_d = tms ? SEL_IR    : CAP_DR;
      CAP_DR:    state_d = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  state_d = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  state_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  state_d = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  state_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: state_d = tms ? SEL_DR    : RTI;
      SEL_IR:    state_d = tms ? TLR       : CAP_IR;
      CAP_IR:    state_d = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  state_d = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  state_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  state_d = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  state_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: state_d = tms ? SEL_DR    : RTI;
      default:   state_d = TLR;
    endcase
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) state_q <= TLR;
    else        state_q <= state_d;
  end

  // tdo is launched on the falling edge so the pin is stable at the next rising edge.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo_d    = ir_sr_lsb;
      tdo_en_d = 1'b1;
    end else if (state_q == SHIFT_DR) begin
      tdo_d    = tdo_dr;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  jtag_ir #(
    .IR_WIDTH       (IR_WIDTH),
    .IR_CAPTURE_VAL (IR_CAPTURE_VAL)
  ) u_ir (
    .tck        (tck),
    .trstn      (trstn),
    .tdi        (tdi),
    .capture_ir (state_q == CAP_IR),
    .shift_ir   (state_q == SHIFT_IR),
    .update_ir  (state_q == UPDATE_IR),
    .tlr        (state_q == TLR),
    .ir_sr_lsb  (ir_sr_lsb),
    .ir_dec     (ir_dec)
  );

  assign tap_state = state_q;
  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboarded bench: driver advances a spec-level TAP model and queues expectations; monitor compares each cycle.
import jtag_pkg::*;

module tb_jtag_tap_ctrl;

  logic          trstn, tck, tms, tdi, tdo_dr;
  logic          tdo, tdo_en;
  tap_ctrl_fsm_t tap_state;
  ir_decoding_t  ir_dec;

  jtag_tap_ctrl dut (
    .trstn(trstn), .tck(tck), .tms(tms), .tdi(tdi), .tdo_dr(tdo_dr),
    .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_dec(ir_dec)
  );

  initial tck = 1'b0;
  always #10 tck = ~tck;

  typedef struct {
    tap_ctrl_fsm_t st;
    ir_decoding_t  dec;
    logic          tdo;
    logic          en;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, got, exp);
    end
  endtask

  // Reference model: transition table built from the state diagram, IR as plain integers.
  tap_ctrl_fsm_t nt[16][2];
  tap_ctrl_fsm_t m_st;
  int unsigned   m_sr, m_ir;
  logic          m_tdo, m_en;
  localparam int unsigned CAPVAL = 4'b0101;

  task automatic set_t(input tap_ctrl_fsm_t s, input tap_ctrl_fsm_t n0, input tap_ctrl_fsm_t n1);
    nt[int'(s)][0] = n0;
    nt[int'(s)][1] = n1;
  endtask

  task automatic build_tbl();
    tap_ctrl_fsm_t cap[2], shf[2], e1[2], pa[2], e2[2], up[2];
    cap = '{CAP_DR, CAP_IR};     shf = '{SHIFT_DR, SHIFT_IR};
    e1  = '{EXIT1_DR, EXIT1_IR}; pa  = '{PAUSE_DR, PAUSE_IR};
    e2  = '{EXIT2_DR, EXIT2_IR}; up  = '{UPDATE_DR, UPDATE_IR};
    set_t(TLR, RTI, TLR);
    set_t(RTI, RTI, SEL_DR);
    set_t(SEL_DR, CAP_DR, SEL_IR);
    set_t(SEL_IR, CAP_IR, TLR);
    for (int c = 0; c < 2; c++) begin
      set_t(cap[c], shf[c], e1[c]);
      set_t(shf[c], shf[c], e1[c]);
      set_t(e1[c],  pa[c],  up[c]);
      set_t(pa[c],  pa[c],  e2[c]);
      set_t(e2[c],  shf[c], up[c]);
      set_t(up[c],  RTI,    SEL_DR);
    end
  endtask

  function automatic ir_decoding_t dec_of(input int unsigned op);
    if (op == OP_IDCODE)           return DEC_IDCODE;
    if (op == OP_ADDR_REGISTER)    return DEC_ADDR_REGISTER;
    if (op == OP_DATA_WR_REGISTER) return DEC_DATA_WR_REGISTER;
    if (op == OP_DATA_RD_REGISTER) return DEC_DATA_RD_REGISTER;
    return DEC_BYPASS;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.st = m_st; e.dec = dec_of(m_ir); e.tdo = m_tdo; e.en = m_en;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = TLR; m_sr = 0; m_ir = OP_IDCODE; m_tdo = 1'b0; m_en = 1'b0;
  endtask

  // One tck period: rising-edge effects, then falling-edge effects.
  task automatic model_step(input logic t, input logic d, input logic dr);
    if (m_st == CAP_IR)        m_sr = CAPVAL;
    else if (m_st == SHIFT_IR) m_sr = (m_sr >> 1) + (d ? 8 : 0);
    m_st  = nt[int'(m_st)][t ? 1 : 0];
    m_en  = (m_st == SHIFT_IR) || (m_st == SHIFT_DR);
    m_tdo = (m_st == SHIFT_IR) ? m_sr[0] : (m_st == SHIFT_DR) ? dr : 1'b0;
    if (m_st == UPDATE_IR) m_ir = m_sr;
    else if (m_st == TLR)  m_ir = OP_IDCODE;
  endtask

  // Inputs change 7 time units after the falling edge; the monitor samples 5 after it.
  task automatic cyc(input logic t, input logic d, input logic dr);
    tms = t; tdi = d; tdo_dr = dr;
    model_step(t, d, dr);
    push_exp();
    @(negedge tck); #7;
  endtask

  task automatic rst_cyc();
    trstn = 1'b0;
    #1;
    chk("rst_now_state", 32'(tap_state), 32'(TLR));
    chk("rst_now_tdo", 32'(tdo), 32'd0);
    chk("rst_now_en", 32'(tdo_en), 32'd0);
    chk("rst_now_dec", 32'(ir_dec), 32'(DEC_IDCODE));
    model_reset();
    push_exp();
    @(negedge tck); #7;
    trstn = 1'b1;
  endtask

  // From RTI: load a 4-bit opcode and return to RTI.
  task automatic load_ir(input logic [3:0] op);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(i == 3, op[i], 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge tck); #5;
      cyc_n++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("state", 32'(tap_state), 32'(e.st));
        chk("ir_dec", 32'(ir_dec), 32'(e.dec));
        chk("tdo", 32'(tdo), 32'(e.tdo));
        chk("tdo_en", 32'(tdo_en), 32'(e.en));
      end
    end
  end

  initial begin : driver
    int n;
    build_tbl();
    trstn = 1'b0; tms = 1'b1; tdi = 1'b0; tdo_dr = 1'b0;
    model_reset();
    @(negedge tck); #7;
    rst_cyc();

    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0);
    load_ir(4'h2);
    load_ir(4'hA);
    load_ir(4'h4);
    load_ir(4'h3);

    // Empty IR scan: CAP_IR -> EXIT1 -> UPDATE leaves the capture pattern.
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    chk("empty_scan_dec", 32'(ir_dec), 32'(DEC_BYPASS));

    // Split IR scan with a 3-cycle pause, opcode 4'h3.
    load_ir(4'h1);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 1, 0); cyc(1, 1, 0);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0); cyc(1, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("pause_scan_dec", 32'(ir_dec), 32'(DEC_DATA_WR_REGISTER));

    // Reset mid IR shift discards the partial opcode.
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0); cyc(0, 1, 0);
    rst_cyc();
    cyc(1, 0, 0); cyc(1, 0, 0);

    // SHIFT_DR with toggling tdo_dr, then reset mid-shift.
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, logic'(i % 2));
    rst_cyc();

    // Five tms=1 edges from every state.
    for (int s = 0; s < 16; s++) begin
      rst_cyc();
      n = 0;
      while (int'(m_st) != s && n < 300) begin
        cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        n++;
      end
      chk("walk_reach", 32'(tap_state), 32'(s));
      for (int k = 0; k < 5; k++) cyc(1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      chk("tlr5_state", 32'(tap_state), 32'(TLR));
      chk("tlr5_dec", 32'(ir_dec), 32'(DEC_IDCODE));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_cyc();
      else cyc(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end

    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge tck); #6;
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
